// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, the two
// requester identities, and default bus widths.
package mem_arb_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker. On a conflict it favours the side that did not
// win last. The history advances only when the owner's transaction completes.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   req_i,
  input  logic   req_d,
  input  logic   update,
  input  owner_t granted,
  output owner_t pick
);

  owner_t last_q;
  owner_t last_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= OWN_D;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (update) begin
      last_d = granted;
    end
  end

  always_comb begin
    if (req_i && req_d) begin
      pick = (last_q == OWN_I) ? OWN_D : OWN_I;
    end else if (req_i) begin
      pick = OWN_I;
    end else begin
      pick = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between the fetch (I) and data (D)
// sides of the CPU, with round-robin arbitration and a response watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_we,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          m_req,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [3:0]    m_we,
  input  logic          m_gnt,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  // A zero TIMEOUT disables the watchdog; keep at least one counter bit anyway.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    we_q,    we_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q,   err_d;

  owner_t        pick;
  logic          arb_update;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .req_i   (i_req),
    .req_d   (d_req),
    .update  (arb_update),
    .granted (owner_q),
    .pick    (pick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = REQ;
          owner_d = pick;
          if (pick == OWN_I) begin
            addr_d  = i_addr;
            wdata_d = '0;
            we_d    = '0;
          end else begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
          end
        end
      end
      REQ: begin
        if (m_gnt) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // A real response wins over a watchdog expiry in the same cycle.
        if (m_rvalid) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = (owner_q == OWN_D && we_q != 4'b0000) ? '0 : m_rdata;
        end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    m_req      = (state_q == REQ);
    busy       = (state_q != IDLE);
    arb_update = (state_q == RESP);
    i_ack      = (state_q == RESP) && (owner_q == OWN_I);
    d_ack      = (state_q == RESP) && (owner_q == OWN_D);
    i_rdata    = ((state_q == RESP) && (owner_q == OWN_I)) ? rdata_q : '0;
    d_rdata    = ((state_q == RESP) && (owner_q == OWN_D)) ? rdata_q : '0;
    i_err      = (state_q == RESP) && (owner_q == OWN_I) && err_q;
    d_err      = (state_q == RESP) && (owner_q == OWN_D) && err_q;
    m_addr     = addr_q;
    m_wdata    = wdata_q;
    m_we       = we_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transactions checked against a round-robin ordering model and a memory model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_we;
  logic          i_ack, d_ack, i_err, d_err;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          m_req, m_gnt, m_rvalid, busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [3:0]    m_we;

  int tests_run    = 0;
  int tests_failed = 0;
  // 0 = I won the last completed transaction, 1 = D
  int model_last   = 1;

  int            gnt_delay    = 0;
  int            rvalid_delay = 0;
  bit            no_resp      = 1'b0;
  bit            late_pulse   = 1'b0;
  bit            rdata_ovr_en = 1'b0;
  logic [DW-1:0] rdata_ovr    = '0;
  logic [AW-1:0] g_addr       = '0;
  logic [DW-1:0] g_wdata      = '0;
  logic [3:0]    g_we         = '0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F1E_2D3C;
  endfunction

  // Memory model: grants after gnt_delay cycles of m_req, responds rvalid_delay
  // cycles into WAIT; stores return junk data that the arbiter must drop.
  initial begin : responder
    int phase;
    int gcnt;
    int rcnt;
    phase = 0; gcnt = 0; rcnt = 0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    forever begin
      @(negedge clk);
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      if (reset !== 1'b1) begin
        phase = 0; gcnt = 0; rcnt = 0;
      end else if (late_pulse) begin
        m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0;
        late_pulse = 1'b0; phase = 0; gcnt = 0;
      end else if (phase == 0) begin
        if (m_req === 1'b1) begin
          if (gcnt >= gnt_delay) begin
            m_gnt = 1'b1;
            g_addr = m_addr; g_wdata = m_wdata; g_we = m_we;
            phase = 1; rcnt = 0;
          end else begin
            gcnt++;
          end
        end else begin
          gcnt = 0;
        end
      end else if (!no_resp) begin
        if (rcnt >= rvalid_delay) begin
          m_rvalid = 1'b1;
          m_rdata  = rdata_ovr_en ? rdata_ovr :
                     ((g_we != 4'b0000) ? 32'hFFFF_FFFF : mem_word(g_addr));
          phase = 0; gcnt = 0;
        end else begin
          rcnt++;
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0; d_we = '0;
    #1;
    tests_run++;
    if ({i_ack, d_ack, i_err, d_err, m_req, busy} !== 6'b0)
      $display("[TB] FAIL reset_ctrl: got %b expected 000000", {i_ack, d_ack, i_err, d_err, m_req, busy});
    tests_run++;
    if ({i_rdata, d_rdata} !== 64'h0)
      $display("[TB] FAIL reset_rdata: got %h expected 0", {i_rdata, d_rdata});
    tests_run++;
    if ({m_addr, m_wdata, m_we} !== 68'h0)
      $display("[TB] FAIL reset_mport: got %h expected 0", {m_addr, m_wdata, m_we});
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_idle: busy got %b expected 0", busy);
    end
    model_last = 1;
  endtask

  task automatic test_single_fetch();
    int lat;
    bit got;
    gnt_delay = 0; rvalid_delay = 0;
    rdata_ovr_en = 1'b1; rdata_ovr = 32'hDEAD_BEEF;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h10;
    lat = 0; got = 1'b0;
    while (!got && lat < 50) begin
      @(negedge clk); lat++;
      if (i_ack === 1'b1) got = 1'b1;
    end
    i_req = 1'b0;
    tests_run++;
    if (!got || lat != 3) begin
      tests_failed++;
      $display("[TB] FAIL fetch_latency: got %0d (acked=%0d) expected 3", lat, got);
    end
    tests_run++;
    if ({i_err, i_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
      tests_failed++;
      $display("[TB] FAIL fetch_data: got err=%b rdata=%h expected err=0 rdata=deadbeef", i_err, i_rdata);
    end
    tests_run++;
    if ({g_addr, g_wdata, g_we, d_ack} !== {32'h10, 32'h0, 4'h0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL fetch_payload: got addr=%h wdata=%h we=%h d_ack=%b expected 10/0/0/0",
               g_addr, g_wdata, g_we, d_ack);
    end
    @(negedge clk);
    tests_run++;
    if ({i_ack, busy} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL fetch_ack_once: got ack=%b busy=%b expected 0 0", i_ack, busy);
    end
    rdata_ovr_en = 1'b0;
    model_last = 0;
  endtask

  task automatic test_store();
    int lat;
    bit got;
    gnt_delay = 0; rvalid_delay = 0;
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678; d_we = 4'b0011;
    lat = 0; got = 1'b0;
    while (!got && lat < 50) begin
      @(negedge clk); lat++;
      if (d_ack === 1'b1) got = 1'b1;
    end
    d_req = 1'b0;
    tests_run++;
    if (!got || lat != 3) begin
      tests_failed++;
      $display("[TB] FAIL store_latency: got %0d (acked=%0d) expected 3", lat, got);
    end
    tests_run++;
    if ({g_addr, g_wdata, g_we} !== {32'h40, 32'h1234_5678, 4'b0011}) begin
      tests_failed++;
      $display("[TB] FAIL store_payload: got %h/%h/%b expected 40/12345678/0011", g_addr, g_wdata, g_we);
    end
    tests_run++;
    if ({d_err, d_rdata, i_ack} !== {1'b0, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL store_resp: got err=%b rdata=%h i_ack=%b expected 0/0/0", d_err, d_rdata, i_ack);
    end
    model_last = 1;
  endtask

  task automatic test_conflict();
    int acks;
    int cyc;
    int side;
    int exp_side;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] obs_rd;
    gnt_delay = 1; rvalid_delay = 1;
    @(negedge clk);
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = 32'h200; d_we = 4'b0000;
    acks = 0; cyc = 0;
    while (acks < 4 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (i_ack === 1'b1 || d_ack === 1'b1) begin
        side     = (i_ack === 1'b1) ? 0 : 1;
        exp_side = (model_last == 1) ? 0 : 1;
        tests_run++;
        if ((i_ack === 1'b1 && d_ack === 1'b1) || side != exp_side) begin
          tests_failed++;
          $display("[TB] FAIL conflict_order: txn %0d got side %0d (i_ack=%b d_ack=%b) expected side %0d",
                   acks, side, i_ack, d_ack, exp_side);
        end
        exp_rd = mem_word(side == 0 ? i_addr : d_addr);
        obs_rd = (side == 0) ? i_rdata : d_rdata;
        tests_run++;
        if (obs_rd !== exp_rd) begin
          tests_failed++;
          $display("[TB] FAIL conflict_data: txn %0d got %h expected %h", acks, obs_rd, exp_rd);
        end
        model_last = side;
        if (side == 0) i_addr = i_addr + 32'h4;
        else           d_addr = d_addr + 32'h4;
        acks++;
        if (acks == 4) begin
          i_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    if (acks < 4) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL conflict_timeout: got %0d acks expected 4", acks);
      i_req = 1'b0; d_req = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit got;
    int busy_bad;
    int payload_bad;
    int mreq_cycles;
    int extra;
    gnt_delay = 5; rvalid_delay = 7;
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h80; d_wdata = 32'h0; d_we = 4'b0000;
    lat = 0; got = 1'b0; busy_bad = 0; payload_bad = 0; mreq_cycles = 0;
    while (!got && lat < 100) begin
      @(negedge clk); lat++;
      if (busy !== 1'b1) busy_bad++;
      if (m_req === 1'b1) begin
        mreq_cycles++;
        if (m_addr !== 32'h80 || m_we !== 4'b0000) payload_bad++;
      end
      if (lat == 2) d_addr = 32'h999;
      if (d_ack === 1'b1) got = 1'b1;
    end
    tests_run++;
    if (!got || lat != 3 + 5 + 7) begin
      tests_failed++;
      $display("[TB] FAIL bp_latency: got %0d (acked=%0d) expected %0d", lat, got, 3 + 5 + 7);
    end
    tests_run++;
    if (d_rdata !== mem_word(32'h80)) begin
      tests_failed++;
      $display("[TB] FAIL bp_data: got %h expected %h", d_rdata, mem_word(32'h80));
    end
    d_req = 1'b0;
    tests_run++;
    if (mreq_cycles != 6 || payload_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL bp_mreq: got %0d cycles, %0d bad payloads expected 6 cycles, 0 bad", mreq_cycles, payload_bad);
    end
    tests_run++;
    if (busy_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL bp_busy: got %0d idle cycles expected 0", busy_bad);
    end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (d_ack === 1'b1 || i_ack === 1'b1) extra++;
    end
    tests_run++;
    if (extra != 0) begin
      tests_failed++;
      $display("[TB] FAIL bp_ack_once: got %0d extra acks expected 0", extra);
    end
    model_last = 1;
  endtask

  task automatic test_timeout();
    int lat;
    bit got;
    int stray;
    gnt_delay = 0; rvalid_delay = 0; no_resp = 1'b1;
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h300; d_we = 4'b0000;
    lat = 0; got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk); lat++;
      if (d_ack === 1'b1) got = 1'b1;
    end
    tests_run++;
    if (!got || lat != TO + 3) begin
      tests_failed++;
      $display("[TB] FAIL timeout_latency: got %0d (acked=%0d) expected %0d", lat, got, TO + 3);
    end
    tests_run++;
    if ({d_err, d_rdata, i_ack} !== {1'b1, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL timeout_resp: got err=%b rdata=%h i_ack=%b expected 1/0/0", d_err, d_rdata, i_ack);
    end
    d_req = 1'b0; no_resp = 1'b0; late_pulse = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (i_ack === 1'b1 || d_ack === 1'b1 || busy !== 1'b0) stray++;
    end
    tests_run++;
    if (stray != 0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_late_rvalid: got %0d active cycles expected 0", stray);
    end
    model_last = 1;
  endtask

  task automatic test_reset_mid_wait();
    int stray;
    int cyc;
    bit got_i;
    bit got_d;
    gnt_delay = 0; rvalid_delay = 6;
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h500; d_we = 4'b0000;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, m_req} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL rmw_in_wait: got busy=%b m_req=%b expected 1 0", busy, m_req);
    end
    reset = 1'b0;
    d_req = 1'b0;
    #1;
    tests_run++;
    if ({i_ack, d_ack, i_err, d_err, m_req, busy, i_rdata, d_rdata, m_addr, m_wdata, m_we} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rmw_outputs: got ack=%b%b m_req=%b busy=%b m_addr=%h expected all 0",
               i_ack, d_ack, m_req, busy, m_addr);
    end
    stray = 0;
    repeat (2) begin
      @(negedge clk);
      if (i_ack === 1'b1 || d_ack === 1'b1) stray++;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (i_ack === 1'b1 || d_ack === 1'b1 || busy !== 1'b0) stray++;
    end
    tests_run++;
    if (stray != 0) begin
      tests_failed++;
      $display("[TB] FAIL rmw_no_ack: got %0d active cycles expected 0", stray);
    end
    model_last = 1;
    gnt_delay = 0; rvalid_delay = 0;
    i_req = 1'b1; i_addr = 32'h600; d_req = 1'b1; d_addr = 32'h700;
    got_i = 1'b0; got_d = 1'b0; cyc = 0;
    while (!got_d && cyc < 100) begin
      @(negedge clk); cyc++;
      if (i_ack === 1'b1 || d_ack === 1'b1) begin
        tests_run++;
        if (got_i == 1'b0 && i_ack !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL rmw_first_grant: got i_ack=%b d_ack=%b expected I first", i_ack, d_ack);
        end
        if (i_ack === 1'b1) begin got_i = 1'b1; i_req = 1'b0; end
        if (d_ack === 1'b1) begin got_d = 1'b1; d_req = 1'b0; end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    if (!got_d) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL rmw_timeout: got no D ack expected one");
    end
    model_last = 1;
  endtask

  task automatic test_random(input int n);
    int exp_q[$];
    int cyc;
    int side;
    bit want_i;
    bit want_d;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] dwd, exp_rd, obs_rd, exp_wd;
    logic [3:0]    dwe, exp_we;
    logic [AW-1:0] exp_a;
    logic          obs_err;
    for (int it = 0; it < n; it++) begin
      want_i = 1'($urandom_range(0, 1));
      want_d = 1'($urandom_range(0, 1));
      if (!want_i && !want_d) want_i = 1'b1;
      ia  = $urandom & 32'hFFFF_FFFC;
      da  = $urandom & 32'hFFFF_FFFC;
      dwd = $urandom;
      dwe = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      gnt_delay    = $urandom_range(0, 3);
      rvalid_delay = $urandom_range(0, 3);
      exp_q.delete();
      if (want_i && want_d) begin
        exp_q.push_back(model_last == 1 ? 0 : 1);
        exp_q.push_back(model_last == 1 ? 1 : 0);
      end else begin
        exp_q.push_back(want_i ? 0 : 1);
      end
      @(negedge clk);
      i_req = want_i; i_addr = ia; d_req = want_d; d_addr = da; d_wdata = dwd; d_we = dwe;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 200) begin
        @(negedge clk); cyc++;
        if (i_ack === 1'b1 || d_ack === 1'b1) begin
          side = (i_ack === 1'b1) ? 0 : 1;
          tests_run++;
          if ((i_ack === 1'b1 && d_ack === 1'b1) || side != exp_q[0]) begin
            tests_failed++;
            $display("[TB] FAIL rand_order: iter %0d got side %0d expected %0d", it, side, exp_q[0]);
          end
          exp_rd  = (side == 0) ? mem_word(ia) : ((dwe == 4'b0000) ? mem_word(da) : '0);
          obs_rd  = (side == 0) ? i_rdata : d_rdata;
          obs_err = (side == 0) ? i_err : d_err;
          tests_run++;
          if ({obs_err, obs_rd} !== {1'b0, exp_rd}) begin
            tests_failed++;
            $display("[TB] FAIL rand_data: iter %0d got err=%b rdata=%h expected err=0 rdata=%h",
                     it, obs_err, obs_rd, exp_rd);
          end
          exp_a  = (side == 0) ? ia : da;
          exp_wd = (side == 0) ? '0 : dwd;
          exp_we = (side == 0) ? 4'b0000 : dwe;
          tests_run++;
          if ({g_addr, g_wdata, g_we} !== {exp_a, exp_wd, exp_we}) begin
            tests_failed++;
            $display("[TB] FAIL rand_payload: iter %0d got %h/%h/%b expected %h/%h/%b",
                     it, g_addr, g_wdata, g_we, exp_a, exp_wd, exp_we);
          end
          void'(exp_q.pop_front());
          model_last = side;
          if (side == 0) i_req = 1'b0;
          else           d_req = 1'b0;
        end
      end
      if (exp_q.size() > 0) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL rand_timeout: iter %0d got %0d acks missing expected 0", it, exp_q.size());
        i_req = 1'b0; d_req = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_conflict();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    test_random(40);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
